// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_pkg;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_e;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

  // Encodes a one-hot vector of up to 8 bits; an all-zero input maps to 0.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of req searching upward from rr_ptr, wrapping at N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  always_comb begin
    int  idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited sharing of the FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int Data_Width = 8,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                          wclk,
  input  logic                          wrst,
  // req/ack handshake: a producer raises req with req_data stable and holds both
  // until ack pulses; ack high in a cycle means that word is written at its closing edge.
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*Data_Width-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          winc,
  output logic [Data_Width-1:0]         data_in,
  output logic                          busy,
  output arb_state_e                    state_dbg
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  arb_state_e        state, state_nx;
  logic [NUM_REQ-1:0] gnt_nx, pick;
  logic [IW-1:0]      rr_ptr, ptr_nx, o, o_next, pick_ptr;
  logic [CW-1:0]      burst_cnt, cnt_nx;
  logic               pick_valid, accept, release_own;

  assign o        = IW'(onehot_to_idx(8'(gnt)));
  assign o_next   = (o == IW'(NUM_REQ - 1)) ? '0 : o + IW'(1);
  assign accept   = (|(gnt & req)) & ~full;
  // In OWN the picker only matters on a release edge, so it already searches from o+1.
  assign pick_ptr = (state == OWN) ? o_next : rr_ptr;
  assign release_own = (accept && (burst_cnt == LAST)) || !req[o];

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .rr_ptr (pick_ptr),
    .pick   (pick),
    .valid  (pick_valid)
  );

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      gnt       <= gnt_nx;
      rr_ptr    <= ptr_nx;
      burst_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    ptr_nx   = rr_ptr;
    cnt_nx   = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_nx = OWN;
          gnt_nx   = pick;
          cnt_nx   = '0;
        end
      end
      OWN: begin
        if (release_own) begin
          ptr_nx = o_next;
          cnt_nx = '0;
          if (pick_valid) begin
            gnt_nx = pick;
          end else begin
            state_nx = IDLE;
            gnt_nx   = '0;
          end
        end else if (accept) begin
          cnt_nx = burst_cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase
  end

  // Everything here derives from the async-cleared gnt, so reset zeroes it at once.
  always_comb begin
    winc      = accept;
    ack       = accept ? gnt : '0;
    data_in   = '0;
    if (gnt != '0) data_in = req_data[int'(o)*Data_Width +: Data_Width];
    busy      = (state == OWN);
    state_dbg = state;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: one task per scenario, hand-computed expectations.
module tb_fifo_wr_arbiter;
  import fifo_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DW      = 8;

  logic                   wclk;
  logic                   wrst;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*DW-1:0]  req_data;
  logic                   full;
  logic [NUM_REQ-1:0]     gnt;
  logic [NUM_REQ-1:0]     ack;
  logic                   winc;
  logic [DW-1:0]          data_in;
  logic                   busy;
  arb_state_e             state_dbg;

  int n_vec;
  int n_err;

  fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .Data_Width(DW), .MAX_BURST(4)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req       (req),
    .req_data  (req_data),
    .full      (full),
    .gnt       (gnt),
    .ack       (ack),
    .winc      (winc),
    .data_in   (data_in),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  task automatic do_reset();
    wrst = 1'b0;
    req  = '0;
    full = 1'b0;
    @(negedge wclk);
    wrst = 1'b1;
  endtask

  task automatic set_slice(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic test_reset();
    wrst = 1'b0;
    req  = 4'b1111;
    full = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_slice(i, 8'hFF);
    @(negedge wclk);
    #1;
    n_vec++;
    if (gnt !== 4'b0000 || winc !== 1'b0 || ack !== 4'b0000 || data_in !== 8'h00 ||
        busy !== 1'b0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL reset: gnt=%b winc=%b ack=%b data=%h busy=%b st=%0d, need all zero/IDLE",
               gnt, winc, ack, data_in, busy, state_dbg);
    end
    req  = '0;
    wrst = 1'b1;
    @(negedge wclk);
  endtask

  task automatic test_single();
    do_reset();
    set_slice(2, 8'hA5);
    req = 4'b0100;
    #1;
    n_vec++;
    if (gnt !== 4'b0000 || winc !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: gnt=%b winc=%b, need 0000/0", gnt, winc);
    end
    @(negedge wclk);
    #1;
    n_vec++;
    if (gnt !== 4'b0100 || winc !== 1'b1 || data_in !== 8'hA5 || ack !== 4'b0100 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant: gnt=%b winc=%b data=%h ack=%b busy=%b, need 0100/1/a5/0100/1",
               gnt, winc, data_in, ack, busy);
    end
    @(negedge wclk);
    req = '0;
    #1;
    n_vec++;
    if (winc !== 1'b0 || ack !== 4'b0000) begin
      n_err++;
      $display("FAIL single_drop: winc=%b ack=%b, need 0/0000", winc, ack);
    end
    @(negedge wclk);
    #1;
    n_vec++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL single_idle_back: gnt=%b busy=%b, need 0000/0", gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_g;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_slice(i, 8'(8'h10 + i));
    req = 4'b1111;
    @(negedge wclk);
    for (int k = 0; k < 17; k++) begin
      exp_g = 4'b0001 << ((k / 4) % 4);
      #1;
      n_vec++;
      if (gnt !== exp_g || winc !== 1'b1 || data_in !== 8'(8'h10 + (k / 4) % 4) || ack !== exp_g) begin
        n_err++;
        $display("FAIL rr_cycle%0d: gnt=%b winc=%b data=%h ack=%b, need %b/1/%h/%b",
                 k, gnt, winc, data_in, ack, exp_g, 8'(8'h10 + (k / 4) % 4), exp_g);
      end
      @(negedge wclk);
    end
    req = '0;
    @(negedge wclk);
  endtask

  task automatic test_full_stall();
    int words;
    logic exp_w;
    words = 0;
    do_reset();
    set_slice(1, 8'h5B);
    set_slice(2, 8'hC3);
    req = 4'b0110;
    @(negedge wclk);
    for (int c = 0; c < 7; c++) begin
      full = (c >= 2 && c <= 4);
      exp_w = !full;
      #1;
      n_vec++;
      if (gnt !== 4'b0010 || winc !== exp_w || ack !== (exp_w ? 4'b0010 : 4'b0000)) begin
        n_err++;
        $display("FAIL stall_cycle%0d: gnt=%b winc=%b ack=%b, need 0010/%b", c, gnt, winc, ack, exp_w);
      end
      if (winc && data_in == 8'h5B) words++;
      @(negedge wclk);
    end
    full = 1'b0;
    #1;
    n_vec++;
    if (words !== 4) begin
      n_err++;
      $display("FAIL stall_words: got %0d words for requester 1, need 4", words);
    end
    n_vec++;
    if (gnt !== 4'b0100 || winc !== 1'b1 || data_in !== 8'hC3) begin
      n_err++;
      $display("FAIL stall_rotate: gnt=%b winc=%b data=%h, need 0100/1/c3", gnt, winc, data_in);
    end
    req = '0;
    @(negedge wclk);
  endtask

  task automatic test_drop();
    do_reset();
    set_slice(0, 8'h11);
    set_slice(3, 8'h33);
    req = 4'b1001;
    @(negedge wclk);
    #1;
    n_vec++;
    if (gnt !== 4'b0001 || winc !== 1'b1 || data_in !== 8'h11) begin
      n_err++;
      $display("FAIL drop_first: gnt=%b winc=%b data=%h, need 0001/1/11", gnt, winc, data_in);
    end
    @(negedge wclk);
    req = 4'b1000;
    #1;
    n_vec++;
    if (gnt !== 4'b0001 || winc !== 1'b0 || ack !== 4'b0000) begin
      n_err++;
      $display("FAIL drop_bubble: gnt=%b winc=%b ack=%b, need 0001/0/0000", gnt, winc, ack);
    end
    @(negedge wclk);
    #1;
    n_vec++;
    if (gnt !== 4'b1000 || winc !== 1'b1 || data_in !== 8'h33 || ack !== 4'b1000) begin
      n_err++;
      $display("FAIL drop_handover: gnt=%b winc=%b data=%h ack=%b, need 1000/1/33/1000",
               gnt, winc, data_in, ack);
    end
    req = '0;
    @(negedge wclk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_slice(2, 8'h7E);
    req = 4'b0100;
    @(negedge wclk);
    for (int c = 0; c < 10; c++) begin
      #1;
      n_vec++;
      if (gnt !== 4'b0100 || winc !== 1'b1 || data_in !== 8'h7E) begin
        n_err++;
        $display("FAIL sole_cycle%0d: gnt=%b winc=%b data=%h, need 0100/1/7e", c, gnt, winc, data_in);
      end
      @(negedge wclk);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_slice(0, 8'h01);
    set_slice(2, 8'h22);
    req = 4'b0100;
    @(negedge wclk);
    @(negedge wclk);
    #1;
    wrst = 1'b0;
    #1;
    n_vec++;
    if (winc !== 1'b0 || gnt !== 4'b0000 || ack !== 4'b0000 || data_in !== 8'h00 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: winc=%b gnt=%b ack=%b data=%h busy=%b, need all zero",
               winc, gnt, ack, data_in, busy);
    end
    @(negedge wclk);
    wrst = 1'b1;
    req  = 4'b0101;
    #1;
    n_vec++;
    if (gnt !== 4'b0000 || winc !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: gnt=%b winc=%b, need 0000/0", gnt, winc);
    end
    @(negedge wclk);
    #1;
    n_vec++;
    if (gnt !== 4'b0001 || winc !== 1'b1 || data_in !== 8'h01) begin
      n_err++;
      $display("FAIL post_reset_grant: gnt=%b winc=%b data=%h, need 0001/1/01", gnt, winc, data_in);
    end
    req = '0;
    @(negedge wclk);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    wrst     = 1'b0;
    req      = '0;
    full     = 1'b0;
    req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_drop();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
